// File: rtl/alu_pkg.sv
// Shared encodings for the shared-ALU scheduler: op codes and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAX = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After a grant, priority passes to the requester that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (advance && (gnt != 2'b00))
      ptr <= gnt[0];
  end

endmodule

// File: rtl/alu_share_sched.sv
// One add/sub/max datapath shared by two requesters; one op in flight at a time,
// result returned on a valid/ready channel tagged with the requester id.
module alu_share_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [1:0]       req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_op1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_carry,
  output logic             resp_id
);

  state_t           state, state_nxt;
  logic [1:0]       gnt;
  logic [1:0]       ready_c;
  logic             advance;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic [WIDTH:0]   alu_res;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 2'b00;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          ready_c   = gnt;
          advance   = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Held low while reset is asserted even if a requester is presenting.
  assign req_ready  = rst_n ? ready_c : 2'b00;
  assign resp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_NOP;
      id_q <= 1'b0;
    end else if (advance) begin
      a_q  <= gnt[1] ? req_a1  : req_a0;
      b_q  <= gnt[1] ? req_b1  : req_b0;
      op_q <= gnt[1] ? req_op1 : req_op0;
      id_q <= gnt[1];
    end
  end

  // Computed at WIDTH+1 bits so the top bit is carry for add and borrow for sub.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_res = {1'b0, a_q} - {1'b0, b_q};
      OP_MAX:  alu_res = {1'b0, (a_q >= b_q) ? a_q : b_q};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data  <= '0;
      resp_carry <= 1'b0;
      resp_id    <= 1'b0;
    end else if (state == S_EXEC) begin
      resp_data  <= alu_res[WIDTH-1:0];
      resp_carry <= alu_res[WIDTH];
      resp_id    <= id_q;
    end
  end

endmodule
